// File: rtl/bp_pkg.sv
// Shared branch-predictor types and constants: update record, default queue
// depth and the 2-bit saturating predictor counter encoding.
package bp_pkg;

  localparam int BQ_DEFAULT_DEPTH = 4;
  localparam int BQ_PC_WIDTH      = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic [BQ_PC_WIDTH-1:0] pc;
    logic                   taken;
  } branch_update_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit incrementer that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_update_queue.sv
// FIFO of resolved branches draining one per cycle into the predictor write port.
// Define BQ_PERF_EN to enable the branch / misprediction statistics counters.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH    = BQ_DEFAULT_DEPTH,
  parameter int PC_WIDTH = BQ_PC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [PC_WIDTH-1:0]        enq_pc,
  input  logic                       enq_taken,
  input  logic                       enq_predicted,
  input  logic                       stall,
  output logic                       upd_write,
  output logic [PC_WIDTH-1:0]        upd_pc,
  output logic                       upd_value,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                branch_count,
  output logic [31:0]                mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                taken;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head_entry;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, do_enq, do_deq;

  // Ready looks only at registered occupancy: a full queue never takes a
  // pass-through entry even when the head is popped in the same cycle.
  assign not_empty = (count_q != '0);
  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign do_enq    = enq_valid && enq_ready;
  assign do_deq    = not_empty && !stall;

  assign head_entry = mem_q[head_q];
  assign upd_write  = do_deq;
  assign upd_pc     = not_empty ? head_entry.pc : '0;
  assign upd_value  = not_empty && head_entry.taken;
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_enq) tail_d = tail_q + 1'b1;
    if (do_deq) head_d = head_q + 1'b1;
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[tail_q] <= {enq_pc, enq_taken};
  end

`ifdef BQ_PERF_EN
  sat_counter32 u_branch_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (do_enq),
    .count_o (branch_count)
  );

  sat_counter32 u_mispredict_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (do_enq && (enq_taken != enq_predicted)),
    .count_o (mispredict_count)
  );
`else
  logic unused_predicted;
  assign unused_predicted = enq_predicted;
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
